// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and small helpers used by
// the timing generator and the rendering blocks.
package vga_pkg;

    localparam int H_VISIBLE_DEF  = 640;
    localparam int H_FRONT_DEF    = 16;
    localparam int H_SYNC_DEF     = 96;
    localparam int H_BACK_DEF     = 48;
    localparam int V_VISIBLE_DEF  = 480;
    localparam int V_FRONT_DEF    = 10;
    localparam int V_SYNC_DEF     = 2;
    localparam int V_BACK_DEF     = 33;
    localparam int UPDATE_DIV_DEF = 4;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int COUNT_W = 10;
    localparam int FRAME_W = 8;

    typedef logic [COUNT_W-1:0] count_t;

    // Per-pixel flags, registered together so they never skew against each other.
    typedef struct packed {
        logic display;
        logic hsync;
        logic vsync;
        logic update;
    } vga_flags_t;

    localparam vga_flags_t FLAGS_RESET = '{display: 1'b1, hsync: 1'b1, vsync: 1'b1, update: 1'b0};

    // Half-open window test: lo <= value < hi.
    function automatic logic in_window(input count_t value, input count_t lo, input count_t hi);
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter with enable; exposes the next value so consumers can register
// derived signals in step with the count itself.
module wrap_counter #(
    parameter int WIDTH   = 10,
    parameter int MODULUS = 800
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_reg;

    // ">=" rather than "==" keeps the count in range even from a corrupted state.
    always_comb begin
        wrap       = en && (count_reg >= LAST);
        count_next = count_reg;
        if (en) begin
            if (count_reg >= LAST) begin
                count_next = '0;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, active-low syncs, display window and
// a game-update tick every UPDATE_DIV frames.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int UPDATE_DIV = UPDATE_DIV_DEF
) (
    input  logic               VGA_clk,
    input  logic               reset,
    output logic [COUNT_W-1:0] xCount,
    output logic [COUNT_W-1:0] yCount,
    output logic               displayArea,
    output logic               hsync,
    output logic               vsync,
    output logic               update
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam count_t H_VIS_END = COUNT_W'(H_VISIBLE);
    localparam count_t V_VIS_END = COUNT_W'(V_VISIBLE);
    localparam count_t HS_START  = COUNT_W'(H_VISIBLE + H_FRONT);
    localparam count_t HS_END    = COUNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam count_t VS_START  = COUNT_W'(V_VISIBLE + V_FRONT);
    localparam count_t VS_END    = COUNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    count_t             x_next;
    count_t             y_next;
    logic               x_wrap;
    logic               y_wrap;
    logic               frame_wrap;
    logic [FRAME_W-1:0] frame_count;
    logic [FRAME_W-1:0] frame_count_next;
    logic               frame_unused;

    vga_flags_t flags_reg;
    vga_flags_t flags_next;

    wrap_counter #(
        .WIDTH   (COUNT_W),
        .MODULUS (H_TOTAL)
    ) u_x_counter (
        .clk        (VGA_clk),
        .srst       (reset),
        .en         (1'b1),
        .count      (xCount),
        .count_next (x_next),
        .wrap       (x_wrap)
    );

    wrap_counter #(
        .WIDTH   (COUNT_W),
        .MODULUS (V_TOTAL)
    ) u_y_counter (
        .clk        (VGA_clk),
        .srst       (reset),
        .en         (x_wrap),
        .count      (yCount),
        .count_next (y_next),
        .wrap       (y_wrap)
    );

    // Frame counter only matters through its wrap, which becomes the update tick.
    wrap_counter #(
        .WIDTH   (FRAME_W),
        .MODULUS (UPDATE_DIV)
    ) u_frame_counter (
        .clk        (VGA_clk),
        .srst       (reset),
        .en         (x_wrap && y_wrap),
        .count      (frame_count),
        .count_next (frame_count_next),
        .wrap       (frame_wrap)
    );

    assign frame_unused = ^{frame_count, frame_count_next};

    // Flags are derived from the counters' next values so that, once registered,
    // they line up exactly with the x/y values presented in the same cycle.
    always_comb begin
        flags_next         = FLAGS_RESET;
        flags_next.display = (x_next < H_VIS_END) && (y_next < V_VIS_END);
        flags_next.hsync   = !in_window(x_next, HS_START, HS_END);
        flags_next.vsync   = !in_window(y_next, VS_START, VS_END);
        flags_next.update  = frame_wrap;
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            flags_reg <= FLAGS_RESET;
        end else begin
            flags_reg <= flags_next;
        end
    end

    assign displayArea = flags_reg.display;
    assign hsync       = flags_reg.hsync;
    assign vsync       = flags_reg.vsync;
    assign update      = flags_reg.update;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster (15x11, 165-cycle frames) so
// whole frames and several update periods fit in a short run.
module tb_vga_timing_gen;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int DIV_A = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [9:0] a_x, a_y, b_x, b_y;
    logic a_disp, a_hs, a_vs, a_upd;
    logic b_disp, b_hs, b_vs, b_upd;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .UPDATE_DIV(DIV_A)
    ) dut_a (
        .VGA_clk(clk), .reset(reset), .xCount(a_x), .yCount(a_y),
        .displayArea(a_disp), .hsync(a_hs), .vsync(a_vs), .update(a_upd)
    );

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .UPDATE_DIV(1)
    ) dut_b (
        .VGA_clk(clk), .reset(reset), .xCount(b_x), .yCount(b_y),
        .displayArea(b_disp), .hsync(b_hs), .vsync(b_vs), .update(b_upd)
    );

    int passed = 0;
    int total = 0;
    int k = 0;
    bit check_en = 1'b0;

    // Cycles since reset release: the only state the reference needs.
    always @(posedge clk) k <= reset ? 0 : k + 1;

    function automatic logic [23:0] model(input int kk, input int div);
        int x, y, f;
        logic disp, hs, vs, upd;
        x    = kk % HT;
        y    = (kk / HT) % VT;
        f    = kk / FT;
        disp = (x < HV) && (y < VV);
        hs   = !((x >= HV + HF) && (x < HV + HF + HS));
        vs   = !((y >= VV + VF) && (y < VV + VF + VS));
        upd  = (kk > 0) && (kk % FT == 0) && (f % div == 0);
        return {10'(x), 10'(y), disp, hs, vs, upd};
    endfunction

    task automatic check_vec(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s k=%0d actual x=%0d y=%0d d/h/v/u=%b required x=%0d y=%0d d/h/v/u=%b",
                      name, k, act[23:14], act[13:4], act[3:0], exp[23:14], exp[13:4], exp[3:0]);
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s k=%0d actual=%0d required=%0d", name, k, act, exp);
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (k != target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (k != target) begin
            total++;
            $display("FAIL run_to_timeout actual=%0d required=%0d", k, target);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_vec("model_a", {a_x, a_y, a_disp, a_hs, a_vs, a_upd}, model(k, DIV_A));
            check_vec("model_b", {b_x, b_y, b_disp, b_hs, b_vs, b_upd}, model(k, 1));
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_en = 1'b1;
        check_lit("rst_x", a_x, 0);
        check_lit("rst_disp", a_disp, 1);
        check_lit("rst_hsync", a_hs, 1);
        check_lit("rst_update", a_upd, 0);
        reset = 1'b0;

        run_to(1);   check_lit("first_x", a_x, 1);  check_lit("first_update", b_upd, 0);
        run_to(10);  check_lit("hsync_start", a_hs, 0);
        run_to(13);  check_lit("hsync_end", a_hs, 1);
        run_to(14);  check_lit("last_x", a_x, 14);  check_lit("line0_y", a_y, 0);
        run_to(15);  check_lit("wrap_x", a_x, 0);   check_lit("step_y", a_y, 1);
        run_to(82);  check_lit("disp_corner", a_disp, 1);
        run_to(83);  check_lit("disp_right", a_disp, 0);
        run_to(90);  check_lit("disp_below", a_disp, 0);
        run_to(104); check_lit("vsync_before", a_vs, 1);
        run_to(105); check_lit("vsync_start", a_vs, 0);
        run_to(134); check_lit("vsync_last", a_vs, 0);
        run_to(135); check_lit("vsync_end", a_vs, 1);
        run_to(165); check_lit("b_tick1", b_upd, 1); check_lit("a_no_tick", a_upd, 0);
                     check_lit("frame_x", a_x, 0);   check_lit("frame_y", a_y, 0);
        run_to(166); check_lit("b_tick_len", b_upd, 0);
        run_to(495); check_lit("a_tick", a_upd, 1);
        run_to(496); check_lit("a_tick_len", a_upd, 0);

        run_to(626);
        check_lit("pre_rst_x", a_x, 11);
        check_lit("pre_rst_y", a_y, 8);
        check_lit("pre_rst_hs", a_hs, 0);
        check_lit("pre_rst_vs", a_vs, 0);
        reset = 1'b1;
        @(negedge clk);
        check_lit("mid_rst_x", a_x, 0);
        check_lit("mid_rst_y", a_y, 0);
        check_lit("mid_rst_hs", a_hs, 1);
        check_lit("mid_rst_vs", a_vs, 1);
        check_lit("mid_rst_upd", a_upd, 0);
        reset = 1'b0;

        run_to(165); check_lit("post_a_no_tick", a_upd, 0); check_lit("post_b_tick", b_upd, 1);
        run_to(330); check_lit("post_a_no_tick2", a_upd, 0);
        run_to(495); check_lit("post_a_tick", a_upd, 1);   check_lit("post_a_x", a_x, 0);
        run_to(520);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16; H_SYNC, default 96; H_BACK, default 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 Parameter V_FRONT, default 10; V_SYNC, default 2; V_BACK, default 33, vertical porch and sync widths in lines.
REQ-005 Parameter UPDATE_DIV, default 4, frames per game-update tick; legal range 1..255.
REQ-006 VGA_clk  input  1  pixel clock; the only clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 xCount  output  10  current pixel column, 0..H_TOTAL-1.
REQ-009 yCount  output  10  current line, 0..V_TOTAL-1.
REQ-010 displayArea  output  1  high while the current pixel is visible.
REQ-011 hsync  output  1  horizontal sync, active-low.
REQ-012 vsync  output  1  vertical sync, active-low.
REQ-013 update  output  1  one-cycle game-tick pulse, once every UPDATE_DIV frames.

Function
REQ-014 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800 by default); V_TOTAL SHALL equal the vertical sum (525 by default).
REQ-015 xCount SHALL increment by 1 on every VGA_clk edge and wrap from H_TOTAL-1 to 0.
REQ-016 yCount SHALL increment only on the edge where xCount wraps, and SHALL wrap from V_TOTAL-1 to 0 on the same edge as xCount wraps.
REQ-017 All outputs SHALL be registered and mutually consistent: in any cycle, displayArea, hsync, vsync and update SHALL reflect the xCount/yCount values presented in that cycle, with zero relative skew.
REQ-018 displayArea SHALL be 1 iff xCount<H_VISIBLE and yCount<V_VISIBLE.
REQ-019 hsync SHALL be 0 iff H_VISIBLE+H_FRONT <= xCount < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default), regardless of yCount.
REQ-020 vsync SHALL be 0 iff V_VISIBLE+V_FRONT <= yCount < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default), for the whole of each such line.
REQ-021 An internal frame counter, 8 bits, 0..UPDATE_DIV-1, SHALL advance on each full-frame wrap (xCount and yCount both wrapping) and wrap to 0 after UPDATE_DIV-1.
REQ-022 update SHALL be 1 for exactly one cycle: the cycle in which xCount=0 and yCount=0 are presented following a frame wrap for which the frame counter wrapped to 0.
REQ-023 With UPDATE_DIV=1, update SHALL pulse at the start of every frame following a wrap.
REQ-024 update SHALL never be asserted during reset nor in the first cycle after reset release.
REQ-025 Counter arithmetic SHALL never produce values of H_TOTAL/V_TOTAL or above; no out-of-range value SHALL appear on xCount/yCount.

Reset
REQ-026 While reset=1 at a clock edge: xCount=0, yCount=0, frame counter=0, displayArea=1, hsync=1, vsync=1, update=0.
REQ-027 Reset asserted mid-line or mid-frame SHALL take effect on the next edge with no partial sync pulse carried over; counting resumes from (0,0) on the first edge after release.

Structure
REQ-028 Default timing constants and the derived H_TOTAL/V_TOTAL SHALL live in the shared package vga_pkg, also used by the apple/snake rendering blocks.
REQ-029 A single sub-module, wrap_counter (parameterised width and modulus, enable input, wrap output), SHALL implement the x, y and frame counters.

Verification
REQ-030 Release reset, run 800 cycles -> xCount 0..799 then 0; yCount steps 0->1 exactly when xCount returns to 0.
REQ-031 Run one line -> hsync low for exactly 96 cycles, xCount 656..751; displayArea high for exactly 640 cycles of each line with yCount<480.
REQ-032 Run one full frame (420000 cycles) -> vsync low exactly while yCount in 490..491 (1600 cycles); displayArea low for all of lines 480..524.
REQ-033 UPDATE_DIV=4, run 5 frames from reset release -> exactly one update pulse, at cycle 1,680,000 after release, with xCount=0, yCount=0; UPDATE_DIV=1 -> pulse at cycles 420000, 840000, ....
REQ-034 Assert reset for 1 cycle at xCount=700, yCount=491 -> next cycle xCount=0, yCount=0, hsync=1, vsync=1, update=0; the next update pulse occurs UPDATE_DIV full frames later.
